conversor_bcd_resultado: RTL

CONVERSOR_BCD_RESULTADO -- requirements
Module: conversor_bcd_resultado

---
 rtl/conversor_bcd_resultado.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/conversor_bcd_resultado.sv
// conversor_bcd_resultado
// Converts the 9-bit ALU result word into three BCD digits (hundreds, tens,
// units) using a sequential double-dabble: one shift/adjust step per clock,
// nine steps per conversion, with valid/ready handshakes on both sides.
//
// Build option: define SIGN_MAG_EN to treat D as 9-bit two's complement and
// report the sign on neg. Without it, D is unsigned 0..511 and neg is tied 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high while CLR is released
// CONV  | one double-dabble step per edge, nine steps in total
// DONE  | digits valid; hold until out_ready, then back to IDLE

module conversor_bcd_resultado (
  input  logic       clk,
  input  logic       CLR,
  input  logic [8:0] D,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] centena,
  output logic [3:0] dezena,
  output logic [3:0] unidade,
  output logic       neg,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd8;

  state_t      state;
  state_t      state_nxt;

  logic [8:0]  work;
  logic [11:0] scratch;
  logic [3:0]  step_cnt;

  logic        accept;
  logic        last_step;
  logic [8:0]  mag;
  logic [11:0] scratch_adj;
  logic [20:0] shift_vec;
  logic [11:0] scratch_nxt;
  logic [8:0]  work_nxt;

  // A BCD digit of 5 or more would overflow past 9 after the shift; +3 fixes it.
  function automatic logic [3:0] dabble(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_step = (state == CONV) && (step_cnt == LAST_STEP);

  assign in_ready  = (state == IDLE) && CLR;
  assign busy      = (state == CONV);
  assign out_valid = (state == DONE);

`ifdef SIGN_MAG_EN
  logic sign_in;
  logic neg_work;

  // Negative words are converted by magnitude; -256 maps to 256, which fits.
  always_comb begin
    sign_in = D[8];
    mag     = D[8] ? (~D + 9'd1) : D;
  end
`else
  // Unsigned interpretation: the magnitude is the word itself.
  always_comb begin
    mag = D;
  end
`endif

  // One double-dabble step: adjust each digit, then shift scratch:work left.
  // The hundreds digit never exceeds 5, so the bit shifted out is always 0.
  always_comb begin
    scratch_adj = {dabble(scratch[11:8]), dabble(scratch[7:4]), dabble(scratch[3:0])};
    shift_vec   = {scratch_adj, work} << 1;
    scratch_nxt = shift_vec[20:9];
    work_nxt    = shift_vec[8:0];
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!CLR) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working shift register, BCD scratch and step counter.
  always_ff @(posedge clk) begin
    if (!CLR) begin
      work     <= '0;
      scratch  <= '0;
      step_cnt <= '0;
    end else if (accept) begin
      work     <= mag;
      scratch  <= '0;
      step_cnt <= '0;
    end else if (state == CONV) begin
      work     <= work_nxt;
      scratch  <= scratch_nxt;
      step_cnt <= step_cnt + 4'd1;
    end
  end

  // Digit outputs update only when the ninth step lands, so they hold the
  // previous result throughout IDLE and CONV; an aborted run leaves zeros.
  always_ff @(posedge clk) begin
    if (!CLR) begin
      centena <= '0;
      dezena  <= '0;
      unidade <= '0;
    end else if (last_step) begin
      centena <= scratch_nxt[11:8];
      dezena  <= scratch_nxt[7:4];
      unidade <= scratch_nxt[3:0];
    end
  end

`ifdef SIGN_MAG_EN
  // Sign captured with the word, published together with the digits.
  always_ff @(posedge clk) begin
    if (!CLR) begin
      neg_work <= 1'b0;
      neg      <= 1'b0;
    end else begin
      if (accept) begin
        neg_work <= sign_in;
      end
      if (last_step) begin
        neg <= neg_work;
      end
    end
  end
`else
  assign neg = 1'b0;
`endif

endmodule
